// File: rtl/iiitb_bcd_scan_disp.sv
// Two-digit BCD display receiver: captures a digit pair, reports binary value and legality,
// and scans both digits onto one 7-segment bus. Define BCD_SCAN_LZB_EN for leading-zero blanking.
module iiitb_bcd_scan_disp #(
  parameter int DIV_W   = 10,
  parameter int DIV_MAX = 999
) (
  input  logic       CK,
  input  logic       RN,
  input  logic       EN,
  input  logic       LD,
  input  logic [3:0] QZ_I,
  input  logic [3:0] QU_I,
  output logic [6:0] SEG,
  output logic [1:0] DIG,
  output logic [6:0] BIN,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SHOW_U = 2'd1,
    ST_SHOW_T = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [3:0]       qz_r;
  logic [3:0]       qu_r;
  logic [6:0]       seg_r;
  logic [1:0]       dig_r;
  logic [6:0]       bin_r;
  logic             err_r;
  logic [6:0]       seg_s;
  logic [1:0]       dig_s;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h01;
    endcase
    return s;
  endfunction

  function automatic logic pair_bad(input logic [3:0] z, input logic [3:0] u);
    return (z > 4'd9) || (u > 4'd9);
  endfunction

  function automatic logic [6:0] pair_bin(input logic [3:0] z, input logic [3:0] u);
    logic [6:0] b;
    if (pair_bad(z, u)) begin
      b = 7'h7F;
    end else begin
      b = ({3'b000, z} * 7'd10) + {3'b000, u};
    end
    return b;
  endfunction

  // Segment/digit selection for the current scan phase.
  always_comb begin
    seg_s = 7'h00;
    dig_s = 2'b00;
    case (state_r)
      ST_SHOW_U: begin
        seg_s = seg_code(qu_r);
        dig_s = 2'b01;
      end
      ST_SHOW_T: begin
`ifdef BCD_SCAN_LZB_EN
        if (qz_r == 4'd0) begin
          seg_s = 7'h00;
          dig_s = 2'b00;
        end else begin
          seg_s = seg_code(qz_r);
          dig_s = 2'b10;
        end
`else
        seg_s = seg_code(qz_r);
        dig_s = 2'b10;
`endif
      end
      default: begin
        seg_s = 7'h00;
        dig_s = 2'b00;
      end
    endcase
  end

  // Capture, scan FSM with prescaler, and registered outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_r <= ST_BLANK;
      div_r   <= '0;
      qz_r    <= 4'd0;
      qu_r    <= 4'd0;
      bin_r   <= 7'd0;
      err_r   <= 1'b0;
      seg_r   <= 7'd0;
      dig_r   <= 2'b00;
    end else begin
      if (LD) begin
        qz_r  <= QZ_I;
        qu_r  <= QU_I;
        bin_r <= pair_bin(QZ_I, QU_I);
        err_r <= pair_bad(QZ_I, QU_I);
      end
      case (state_r)
        ST_BLANK: begin
          // Counting starts one cycle after the first load, from a clean prescaler.
          if (LD) begin
            state_r <= ST_SHOW_U;
            div_r   <= '0;
          end
        end
        ST_SHOW_U, ST_SHOW_T: begin
          if (EN) begin
            if (div_r == DIV_LAST) begin
              div_r   <= '0;
              state_r <= (state_r == ST_SHOW_U) ? ST_SHOW_T : ST_SHOW_U;
            end else begin
              div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= ST_BLANK;
          div_r   <= '0;
        end
      endcase
      seg_r <= seg_s;
      dig_r <= dig_s;
    end
  end

  assign SEG = seg_r;
  assign DIG = dig_r;
  assign BIN = bin_r;
  assign ERR = err_r;

endmodule

// File: tb/tb_iiitb_bcd_scan_disp.sv
// Self-checking bench for iiitb_bcd_scan_disp with DIV_MAX=3 (4 enabled clocks per digit).
module tb_iiitb_bcd_scan_disp;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       EN = 1'b0;
  logic       LD = 1'b0;
  logic [3:0] QZ_I = 4'd0;
  logic [3:0] QU_I = 4'd0;
  logic [6:0] SEG;
  logic [1:0] DIG;
  logic [6:0] BIN;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] qz;
    logic [3:0] qu;
    logic [6:0] bin;
    logic       err;
    logic [6:0] seg_u;
    logic [6:0] seg_t;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];

  iiitb_bcd_scan_disp #(.DIV_W(10), .DIV_MAX(3)) dut (
    .CK(CK), .RN(RN), .EN(EN), .LD(LD), .QZ_I(QZ_I), .QU_I(QU_I),
    .SEG(SEG), .DIG(DIG), .BIN(BIN), .ERR(ERR)
  );

  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CK);
  endtask

  task automatic do_reset();
    RN = 1'b0; LD = 1'b0; EN = 1'b0;
    tick(); tick();
    RN = 1'b1;
  endtask

  task automatic load(input logic [3:0] z, input logic [3:0] u);
    QZ_I = z; QU_I = u; LD = 1'b1;
    tick();
    LD = 1'b0;
  endtask

  task automatic check_slot(input string name, input logic [1:0] d, input logic [6:0] s);
    check({name, "_dig"}, {6'd0, DIG}, {6'd0, d});
    check({name, "_seg"}, {1'b0, SEG}, {1'b0, s});
  endtask

  initial begin
    vec_t v;
    logic [6:0] st;
    logic [1:0] dt;

    vecs[0] = '{qz: 4'h4, qu: 4'h2, bin: 7'h2A, err: 1'b0, seg_u: 7'h6D, seg_t: 7'h33};
    vecs[1] = '{qz: 4'hA, qu: 4'h3, bin: 7'h7F, err: 1'b1, seg_u: 7'h79, seg_t: 7'h01};
    vecs[2] = '{qz: 4'h9, qu: 4'h9, bin: 7'h63, err: 1'b0, seg_u: 7'h7B, seg_t: 7'h7B};
    vecs[3] = '{qz: 4'h0, qu: 4'h7, bin: 7'h07, err: 1'b0, seg_u: 7'h70, seg_t: 7'h7E};
    vecs[4] = '{qz: 4'h1, qu: 4'h0, bin: 7'h0A, err: 1'b0, seg_u: 7'h7E, seg_t: 7'h30};
    vecs[5] = '{qz: 4'h5, qu: 4'hB, bin: 7'h7F, err: 1'b1, seg_u: 7'h01, seg_t: 7'h5B};
    vecs[6] = '{qz: 4'h6, qu: 4'h8, bin: 7'h44, err: 1'b0, seg_u: 7'h7F, seg_t: 7'h5F};
    vecs[7] = '{qz: 4'hF, qu: 4'hF, bin: 7'h7F, err: 1'b1, seg_u: 7'h01, seg_t: 7'h01};

    // Reset state, no load for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_slot("idle", 2'b00, 7'h00);
      check("idle_bin", {1'b0, BIN}, 8'h00);
      check("idle_err", {7'd0, ERR}, 8'h00);
    end

    // Table-driven: each vector from a fresh BLANK state
    for (int n = 0; n < 8; n++) begin
      do_reset();
      EN = 1'b1;
      sb_q.push_back(vecs[n]);
      load(vecs[n].qz, vecs[n].qu);
      if (sb_q.size() == 0) begin
        check("sb_empty", 8'd0, 8'd1);
      end else begin
        v = sb_q.pop_front();
        check("bin", {1'b0, BIN}, {1'b0, v.bin});
        check("err", {7'd0, ERR}, {7'd0, v.err});
        check_slot("blank_after_ld", 2'b00, 7'h00);
        st = v.seg_t;
        dt = 2'b10;
`ifdef BCD_SCAN_LZB_EN
        if (v.qz == 4'd0) begin
          st = 7'h00;
          dt = 2'b00;
        end
`endif
        for (int k = 1; k <= 9; k++) begin
          tick();
          if (k <= 4 || k == 9) check_slot("units", 2'b01, v.seg_u);
          else check_slot("tens", dt, st);
        end
      end
    end

    // ERR is not sticky: bad pair then good pair
    load(4'hA, 4'h3);
    check("err_bad", {7'd0, ERR}, 8'h01);
    load(4'h9, 4'h9);
    check("err_clear", {7'd0, ERR}, 8'h00);
    check("bin_99", {1'b0, BIN}, 8'h63);

    // EN=0 freeze mid-phase, then only remaining counts complete
    do_reset();
    EN = 1'b1;
    load(4'h4, 4'h2);
    tick(); tick();
    EN = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_slot("frozen", 2'b01, 7'h6D);
    end
    EN = 1'b1;
    tick(); check_slot("resume1", 2'b01, 7'h6D);
    tick(); check_slot("resume2", 2'b01, 7'h6D);
    tick(); check_slot("resume_tens", 2'b10, 7'h33);

    // LD while scanning keeps the phase; LD on a wrap edge shows new data one cycle later
    do_reset();
    EN = 1'b1;
    load(4'h4, 4'h2);
    tick(); tick();
    load(4'h9, 4'h9);
    check_slot("ld_scan_old", 2'b01, 7'h6D);
    QZ_I = 4'h1; QU_I = 4'h5; LD = 1'b1;
    tick();
    LD = 1'b0;
    check_slot("ld_scan_new", 2'b01, 7'h7B);
    tick(); check_slot("ld_wrap_tens", 2'b10, 7'h30);
    check("ld_wrap_bin", {1'b0, BIN}, 8'h0F);

    // Async reset between edges, then stay blank until the next load
    tick();
    #2 RN = 1'b0;
    #1;
    check_slot("async_rst", 2'b00, 7'h00);
    check("async_rst_bin", {1'b0, BIN}, 8'h00);
    check("async_rst_err", {7'd0, ERR}, 8'h00);
    tick();
    RN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_slot("post_rst", 2'b00, 7'h00);
    end
    load(4'h3, 4'h8);
    tick(); check_slot("post_rst_ld", 2'b01, 7'h7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
